// File: rtl/counter_pkg.sv
// Shared constants and helpers for the multi-channel counter library.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DIV0_RST_DEF = 1;
  localparam int DIVN_RST_DEF = 4;

  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: count, prescaler, divisor and registered wrap flag.
// Build option MULTI_COUNTER_SAT_EN switches modular wrap to saturation.
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int PRE_W   = 8,
  parameter int DIV_RST = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             sel,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cfg,
  input  logic [PRE_W-1:0] cfg_div,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [PRE_W-1:0] div;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_last;
  logic [WIDTH:0]   step_res;

  // Returns {limit_hit, next_count} for one step in direction d.
  function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] c, input logic d);
    logic             at_lim;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] nxt;
    at_lim  = (d == DIR_UP) ? (c == {WIDTH{1'b1}}) : (c == '0);
    stepped = (d == DIR_UP) ? (c + WIDTH'(1)) : (c - WIDTH'(1));
`ifdef MULTI_COUNTER_SAT_EN
    nxt = at_lim ? c : stepped;
`else
    nxt = stepped;
`endif
    return {at_lim, nxt};
  endfunction

  // A zero divisor behaves as one, so the last prescaler value is then 0.
  assign pre_last = (div == '0) ? '0 : (div - PRE_W'(1));
  assign step_res = step_fn(count, dir);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
      pre   <= '0;
      div   <= PRE_W'(DIV_RST);
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= load_val;
        pre   <= '0;
      end else if (cfg) begin
        div <= cfg_div;
        pre <= '0;
      end else if (sel && en) begin
        if (pre == pre_last) begin
          pre   <= '0;
          count <= step_res[WIDTH-1:0];
          wrap  <= step_res[WIDTH];
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/multi_counter.sv
// NCH-channel event counter with per-channel prescaler, direction and load.
// Build option MULTI_COUNTER_SAT_EN makes every channel saturate instead of wrap.
module multi_counter
  import counter_pkg::*;
#(
  parameter  int WIDTH    = 64,
  parameter  int NCH      = 2,
  parameter  int PRE_W    = 8,
  parameter  int DIV0_RST = DIV0_RST_DEF,
  parameter  int DIVN_RST = DIVN_RST_DEF,
  localparam int CH_W     = ch_idx_w(NCH)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               En,
  input  logic [CH_W-1:0]    Sel,
  input  logic               Dir,
  input  logic               Load,
  input  logic [WIDTH-1:0]   LoadVal,
  input  logic               CfgWe,
  input  logic [CH_W-1:0]    CfgCh,
  input  logic [PRE_W-1:0]   CfgDiv,
  output logic [NCH*WIDTH-1:0] Count,
  output logic [NCH-1:0]     Wrap
);

  // Out-of-range Sel/CfgCh match no channel, so they are silently ignored.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel_hit;
    logic cfg_hit;
    assign sel_hit = (Sel == CH_W'(i));
    assign cfg_hit = (CfgCh == CH_W'(i));

    counter_channel #(
      .WIDTH   (WIDTH),
      .PRE_W   (PRE_W),
      .DIV_RST ((i == 0) ? DIV0_RST : DIVN_RST)
    ) u_ch (
      .Clk      (Clk),
      .Reset    (Reset),
      .sel      (sel_hit),
      .en       (En),
      .dir      (Dir),
      .load     (Load && sel_hit),
      .load_val (LoadVal),
      .cfg      (CfgWe && cfg_hit),
      .cfg_div  (CfgDiv),
      .count    (Count[i*WIDTH +: WIDTH]),
      .wrap     (Wrap[i])
    );
  end

endmodule
